sram_image_loader: RTL and testbench

Write side of the SRAM image store: receives a byte stream of packed 4-bit pixels, pairs bytes into 16-bit words, and writes them to sequential SRAM addresses starting at 20'h00000. It fills the image regions in map, player, bullet, caption and background order, which is the layout the VGA renderers read back. The renderer reads SRAM only after `o_done` is asserted; while `o_busy` is high the loader is the sole SRAM master.

---
 rtl/sram_image_loader.sv | 129 ++++++++++++
 tb/tb_sram_image_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_image_loader.sv
// rtl/sram_image_loader.sv - byte stream to 16-bit SRAM word writer (optional SRAM_LOADER_CHECKSUM_EN adds o_checksum)
module sram_image_loader #(
    parameter int TOTAL_WORDS = 1048576,
    parameter int ADDR_W      = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [20:0]       o_word_count,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_dq,
    output logic              o_sram_dq_oe,
    output logic              o_sram_we_n,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_lb_n,
`ifdef SRAM_LOADER_CHECKSUM_EN
    output logic              o_sram_ub_n,
    output logic [15:0]       o_checksum
`else
    output logic              o_sram_ub_n
`endif
);

    localparam logic [20:0] LAST_COUNT = 21'(TOTAL_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        RECV_HI,
        RECV_LO,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        busy_nxt;
    logic        dq_oe_nxt;
    logic [7:0]  byte_hi;
    logic [20:0] count_inc;

    assign count_inc = o_word_count + 21'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RECV_HI;
            RECV_HI: if (i_valid) state_nxt = RECV_LO;
            RECV_LO: if (i_valid) state_nxt = SETUP;
            SETUP:   state_nxt = PULSE;
            PULSE:   state_nxt = HOLD;
            HOLD:    state_nxt = (count_inc == LAST_COUNT) ? DONE : RECV_HI;
            DONE:    if (i_start) state_nxt = RECV_HI;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt  = (state_nxt == RECV_HI) || (state_nxt == RECV_LO) ||
                    (state_nxt == SETUP)   || (state_nxt == PULSE)   ||
                    (state_nxt == HOLD);
        dq_oe_nxt = (state_nxt == SETUP) || (state_nxt == PULSE) || (state_nxt == HOLD);
    end

    // Strobes are derived from the next state so every output is a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            byte_hi      <= 8'h00;
            o_ready      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_word_count <= 21'd0;
            o_sram_addr  <= '0;
            o_sram_dq    <= 16'h0000;
            o_sram_dq_oe <= 1'b0;
            o_sram_we_n  <= 1'b1;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
`ifdef SRAM_LOADER_CHECKSUM_EN
            o_checksum   <= 16'h0000;
`endif
        end else begin
            state        <= state_nxt;
            o_ready      <= (state_nxt == RECV_HI) || (state_nxt == RECV_LO);
            o_busy       <= busy_nxt;
            o_done       <= (state_nxt == DONE);
            o_sram_dq_oe <= dq_oe_nxt;
            o_sram_we_n  <= (state_nxt != PULSE);
            o_sram_ce_n  <= !busy_nxt;
            o_sram_oe_n  <= 1'b1;
            o_sram_lb_n  <= !busy_nxt;
            o_sram_ub_n  <= !busy_nxt;

            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        o_sram_addr  <= '0;
                        o_word_count <= 21'd0;
`ifdef SRAM_LOADER_CHECKSUM_EN
                        o_checksum   <= 16'h0000;
`endif
                    end
                end
                RECV_HI: if (i_valid) byte_hi <= i_data;
                RECV_LO: if (i_valid) o_sram_dq <= {byte_hi, i_data};
                HOLD: begin
                    // Address wraps after the last word, but DONE is entered on the same edge.
                    o_sram_addr  <= o_sram_addr + ADDR_W'(1);
                    o_word_count <= count_inc;
`ifdef SRAM_LOADER_CHECKSUM_EN
                    o_checksum   <= o_checksum + o_sram_dq;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_image_loader.sv
// tb/tb_sram_image_loader.sv - directed vector bench for sram_image_loader
module tb_sram_image_loader;

    logic        clk = 1'b0;
    logic        rst, start_a, valid_a, start_b, valid_b;
    logic [7:0]  data_a, data_b;
    logic        ready_a, busy_a, done_a, dq_oe_a, we_a, ce_a, oe_a, lb_a, ub_a;
    logic [20:0] count_a;
    logic [19:0] addr_a;
    logic [15:0] dq_a;
    logic        ready_b, busy_b, done_b, dq_oe_b, we_b, ce_b, oe_b, lb_b, ub_b;
    logic [20:0] count_b;
    logic [2:0]  addr_b;
    logic [15:0] dq_b;
`ifdef SRAM_LOADER_CHECKSUM_EN
    logic [15:0] cks_a, cks_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_image_loader #(.TOTAL_WORDS(2), .ADDR_W(20)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_data(data_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_busy(busy_a), .o_done(done_a), .o_word_count(count_a),
        .o_sram_addr(addr_a), .o_sram_dq(dq_a), .o_sram_dq_oe(dq_oe_a),
        .o_sram_we_n(we_a), .o_sram_ce_n(ce_a), .o_sram_oe_n(oe_a),
        .o_sram_lb_n(lb_a),
`ifdef SRAM_LOADER_CHECKSUM_EN
        .o_sram_ub_n(ub_a), .o_checksum(cks_a)
`else
        .o_sram_ub_n(ub_a)
`endif
    );

    sram_image_loader #(.TOTAL_WORDS(8), .ADDR_W(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_data(data_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_busy(busy_b), .o_done(done_b), .o_word_count(count_b),
        .o_sram_addr(addr_b), .o_sram_dq(dq_b), .o_sram_dq_oe(dq_oe_b),
        .o_sram_we_n(we_b), .o_sram_ce_n(ce_b), .o_sram_oe_n(oe_b),
        .o_sram_lb_n(lb_b),
`ifdef SRAM_LOADER_CHECKSUM_EN
        .o_sram_ub_n(ub_b), .o_checksum(cks_b)
`else
        .o_sram_ub_n(ub_b)
`endif
    );

    logic [19:0] log_addr_a[$];
    logic [15:0] log_data_a[$];
    logic [2:0]  log_addr_b[$];
    logic [15:0] log_data_b[$];
    int          accepted_a = 0;

    always @(negedge clk) begin
        if (!we_a) begin
            log_addr_a.push_back(addr_a);
            log_data_a.push_back(dq_a);
        end
        if (!we_b) begin
            log_addr_b.push_back(addr_b);
            log_data_b.push_back(dq_b);
        end
    end

    always @(posedge clk) if (ready_a && valid_a) accepted_a <= accepted_a + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [7:0] b);
        int n = 0;
        while (!ready_a && n < 50) begin step(); n++; end
        check("feed_a_ready_timeout", 32'(n >= 50), 32'd0);
        valid_a = 1'b1;
        data_a  = b;
        step();
        valid_a = 1'b0;
    endtask

    task automatic feed_b(input logic [7:0] b);
        int n = 0;
        while (!ready_b && n < 50) begin step(); n++; end
        check("feed_b_ready_timeout", 32'(n >= 50), 32'd0);
        valid_b = 1'b1;
        data_b  = b;
        step();
        valid_b = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 200) begin step(); n++; end
        check("done_a_timeout", 32'(n >= 200), 32'd0);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
        log_addr_a.delete(); log_data_a.delete();
        log_addr_b.delete(); log_data_b.delete();
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    typedef struct {
        logic        rst, start, valid;
        logic [7:0]  data;
        logic        ready, busy, we_n, ce_n, dq_oe, done;
        logic [19:0] addr;
        logic [15:0] dq;
        logic [20:0] count;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] d, logic rdy, logic bsy,
                                logic we, logic ce, logic oe, logic dn, logic [19:0] ad,
                                logic [15:0] q, logic [20:0] c);
        vec_t t;
        t.rst = r; t.start = s; t.valid = v; t.data = d;
        t.ready = rdy; t.busy = bsy; t.we_n = we; t.ce_n = ce; t.dq_oe = oe; t.done = dn;
        t.addr = ad; t.dq = q; t.count = c;
        return t;
    endfunction

    vec_t        vecs[13];
    logic [7:0]  bytes[4];

    initial begin
        rst = 1'b1; start_a = 0; valid_a = 0; data_a = 0; start_b = 0; valid_b = 0; data_b = 0;
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;

        //            rst st vl data  rdy bsy we ce oe dn addr  dq        cnt
        vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 20'd0, 16'h0000, 21'd0);
        vecs[1]  = mk(0, 1, 0, 8'h00, 1, 1, 1, 0, 0, 0, 20'd0, 16'h0000, 21'd0);
        vecs[2]  = mk(0, 0, 1, 8'h12, 1, 1, 1, 0, 0, 0, 20'd0, 16'h0000, 21'd0);
        vecs[3]  = mk(0, 0, 1, 8'h34, 0, 1, 1, 0, 1, 0, 20'd0, 16'h1234, 21'd0);
        vecs[4]  = mk(0, 0, 1, 8'h99, 0, 1, 0, 0, 1, 0, 20'd0, 16'h1234, 21'd0);
        vecs[5]  = mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 20'd0, 16'h1234, 21'd0);
        vecs[6]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 20'd1, 16'h1234, 21'd1);
        vecs[7]  = mk(0, 0, 1, 8'h56, 1, 1, 1, 0, 0, 0, 20'd1, 16'h1234, 21'd1);
        vecs[8]  = mk(0, 0, 1, 8'h78, 0, 1, 1, 0, 1, 0, 20'd1, 16'h5678, 21'd1);
        vecs[9]  = mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 20'd1, 16'h5678, 21'd1);
        vecs[10] = mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 20'd1, 16'h5678, 21'd1);
        vecs[11] = mk(0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 20'd2, 16'h5678, 21'd2);
        vecs[12] = mk(0, 0, 1, 8'hAA, 0, 0, 1, 1, 0, 1, 20'd2, 16'h5678, 21'd2);

        step();
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; start_a = vecs[i].start; valid_a = vecs[i].valid; data_a = vecs[i].data;
            step();
            check($sformatf("v%0d.ready", i), 32'(ready_a), 32'(vecs[i].ready));
            check($sformatf("v%0d.busy", i), 32'(busy_a), 32'(vecs[i].busy));
            check($sformatf("v%0d.we_n", i), 32'(we_a), 32'(vecs[i].we_n));
            check($sformatf("v%0d.ce_n", i), 32'(ce_a), 32'(vecs[i].ce_n));
            check($sformatf("v%0d.dq_oe", i), 32'(dq_oe_a), 32'(vecs[i].dq_oe));
            check($sformatf("v%0d.done", i), 32'(done_a), 32'(vecs[i].done));
            check($sformatf("v%0d.addr", i), 32'(addr_a), 32'(vecs[i].addr));
            check($sformatf("v%0d.dq", i), 32'(dq_a), 32'(vecs[i].dq));
            check($sformatf("v%0d.count", i), 32'(count_a), 32'(vecs[i].count));
            check($sformatf("v%0d.oe_n", i), 32'(oe_a), 32'd1);
            check($sformatf("v%0d.lb_ub", i), 32'({lb_a, ub_a}), vecs[i].busy ? 32'd0 : 32'd3);
            if (i == 0) log_addr_a.delete();
            if (i == 0) log_data_a.delete();
        end
        check("tbl.writes", 32'(log_addr_a.size()), 32'd2);
        if (log_addr_a.size() == 2) begin
            check("tbl.w0", {log_addr_a[0][15:0], log_data_a[0]}, {16'h0000, 16'h1234});
            check("tbl.w1", {log_addr_a[1][15:0], log_data_a[1]}, {16'h0001, 16'h5678});
        end
        start_a = 0; valid_a = 0;

        // valid toggling with junk presented while not ready
        reset_all();
        pulse_start_a();
        accepted_a = 0;
        begin
            int idx = 0;
            for (int c = 0; c < 80 && !done_a; c++) begin
                if (c % 2 == 0) begin
                    valid_a = 1'b1;
                    data_a  = (ready_a && idx < 4) ? bytes[idx] : 8'hEE;
                    if (ready_a && idx < 4) idx++;
                end else begin
                    valid_a = 1'b0;
                end
                step();
            end
            valid_a = 1'b0;
        end
        check("tog.done", 32'(done_a), 32'd1);
        check("tog.accepted", 32'(accepted_a), 32'd4);
        check("tog.writes", 32'(log_addr_a.size()), 32'd2);
        if (log_addr_a.size() == 2) begin
            check("tog.w0", {log_addr_a[0][15:0], log_data_a[0]}, {16'h0000, 16'h1234});
            check("tog.w1", {log_addr_a[1][15:0], log_data_a[1]}, {16'h0001, 16'h5678});
        end

        // reset during PULSE of word 1
        reset_all();
        pulse_start_a();
        for (int i = 0; i < 4; i++) feed_a(bytes[i]);
        begin
            int n = 0;
            while (!(we_a == 1'b0 && addr_a == 20'd1) && n < 20) begin step(); n++; end
            check("rst.reach_pulse", 32'(n >= 20), 32'd0);
        end
        rst = 1'b1;
        step();
        check("rst.we_n", 32'(we_a), 32'd1);
        check("rst.dq_oe", 32'(dq_oe_a), 32'd0);
        check("rst.busy", 32'(busy_a), 32'd0);
        check("rst.count", 32'(count_a), 32'd0);
        check("rst.addr", 32'(addr_a), 32'd0);
        check("rst.ready", 32'(ready_a), 32'd0);
        rst = 1'b0;
        log_addr_a.delete(); log_data_a.delete();
        pulse_start_a();
        for (int i = 0; i < 4; i++) feed_a(bytes[i]);
        wait_done_a();
        check("rst.count2", 32'(count_a), 32'd2);
        check("rst.writes", 32'(log_addr_a.size()), 32'd2);
        if (log_addr_a.size() == 2) begin
            check("rst.w0", {log_addr_a[0][15:0], log_data_a[0]}, {16'h0000, 16'h1234});
            check("rst.w1", {log_addr_a[1][15:0], log_data_a[1]}, {16'h0001, 16'h5678});
        end

        // start mid-load ignored, start in DONE restarts
        reset_all();
        pulse_start_a();
        feed_a(8'h12); feed_a(8'h34);
        begin
            int n = 0;
            while (!ready_a && n < 20) begin step(); n++; end
            check("mid.reach_recv", 32'(n >= 20), 32'd0);
        end
        pulse_start_a();
        check("mid.busy", 32'(busy_a), 32'd1);
        check("mid.count", 32'(count_a), 32'd1);
        check("mid.addr", 32'(addr_a), 32'd1);
        feed_a(8'h56); feed_a(8'h78);
        wait_done_a();
        check("mid.done_count", 32'(count_a), 32'd2);
        pulse_start_a();
        check("restart.done", 32'(done_a), 32'd0);
        check("restart.count", 32'(count_a), 32'd0);
        check("restart.addr", 32'(addr_a), 32'd0);
        check("restart.ready", 32'(ready_a), 32'd1);
`ifdef SRAM_LOADER_CHECKSUM_EN
        check("cks.cleared", 32'(cks_a), 32'd0);
        feed_a(8'hFF); feed_a(8'hFF); feed_a(8'h00); feed_a(8'h02);
        wait_done_a();
        check("cks.value", 32'(cks_a), 32'h0001);
`else
        for (int i = 0; i < 4; i++) feed_a(bytes[i]);
        wait_done_a();
`endif

        // full address space on a narrow instance: last write at max address, no wrap write
        reset_all();
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int i = 0; i < 16; i++) feed_b(8'hFF);
        begin
            int n = 0;
            while (!done_b && n < 50) begin step(); n++; end
            check("wrap.done_timeout", 32'(n >= 50), 32'd0);
        end
        repeat (5) step();
        check("wrap.done", 32'(done_b), 32'd1);
        check("wrap.count", 32'(count_b), 32'd8);
        check("wrap.writes", 32'(log_addr_b.size()), 32'd8);
        if (log_addr_b.size() == 8) begin
            check("wrap.last_addr", 32'(log_addr_b[7]), 32'd7);
            check("wrap.last_data", 32'(log_data_b[7]), 32'hFFFF);
            check("wrap.first_addr", 32'(log_addr_b[0]), 32'd0);
        end
        check("wrap.dq_oe", 32'(dq_oe_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
